// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared branch-control constants and state encoding
// Purpose: branch type codes, branch FSM state type and the default counter width.
// Ports: none (package).
package mips_ctrl_pkg;

    localparam logic [1:0] BR_BEZ  = 2'b00;
    localparam logic [1:0] BR_BNE  = 2'b01;
    localparam logic [1:0] BR_JMP  = 2'b10;
    localparam logic [1:0] BR_NONE = 2'b11;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } bcu_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition and operand-use decode
// Purpose: decides whether a branch is taken and which source registers it reads.
// Ports:
//   br_type   in  2       branch type code
//   reg1      in  DATA_W  value of first source register
//   reg2      in  DATA_W  value of second source register
//   taken     out 1       branch condition holds
//   uses_src1 out 1       branch reads src1
//   uses_src2 out 1       branch reads src2
module branch_cond_eval
    import mips_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        br_type,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    output logic              taken,
    output logic              uses_src1,
    output logic              uses_src2
);

    always_comb begin
        taken     = 1'b0;
        uses_src1 = 1'b0;
        uses_src2 = 1'b0;
        case (br_type)
            BR_BEZ: begin
                taken     = (reg1 == '0);
                uses_src1 = 1'b1;
            end
            BR_BNE: begin
                taken     = (reg1 != reg2);
                uses_src1 = 1'b1;
                uses_src2 = 1'b1;
            end
            BR_JMP: begin
                taken     = 1'b1;
            end
            default: begin
                taken     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_control_unit.sv
// rtl/branch_control_unit.sv - ID-stage branch resolution, hazard stall and redirect
// Purpose: stalls branches whose operands are still in flight in EX/MEM, resolves
//   them, and issues a one-cycle PC redirect plus IF/ID flush for taken branches.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_valid, id_br_type        ID instruction valid and branch type
//   id_src1, id_src2            branch source registers
//   reg1, reg2                  register-file values of the sources
//   id_br_target                computed branch target
//   ex_wb_en, ex_dest           EX-stage writer
//   mem_wb_en, mem_dest         MEM-stage writer
//   stall                       freeze front end (combinational)
//   pc_sel, flush               redirect PC / squash IF/ID (one cycle)
//   br_target                   latched branch target
//   taken_cnt, stall_cnt        saturating performance counters
module branch_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [1:0]        id_br_type,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [DATA_W-1:0] id_br_target,
    input  logic              ex_wb_en,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] mem_dest,
    output logic              stall,
    output logic              pc_sel,
    output logic              flush,
    output logic [DATA_W-1:0] br_target,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    bcu_state_t state, state_nxt;

    logic is_branch;
    logic cond_taken;
    logic uses_src1;
    logic uses_src2;
    logic hazard;
    logic resolve_taken;

    branch_cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond (
        .br_type   (id_br_type),
        .reg1      (reg1),
        .reg2      (reg2),
        .taken     (cond_taken),
        .uses_src1 (uses_src1),
        .uses_src2 (uses_src2)
    );

    // Register 0 is hardwired, so a pending write to it never blocks a read.
    // WB writers are not checked: the register file writes before it is read.
    function automatic logic src_hazard(input logic [REG_AW-1:0] src);
        return (src != '0) &&
               ((ex_wb_en && (ex_dest == src)) || (mem_wb_en && (mem_dest == src)));
    endfunction

    assign is_branch = id_valid && (id_br_type != BR_NONE);
    assign hazard    = (uses_src1 && src_hazard(id_src1)) ||
                       (uses_src2 && src_hazard(id_src2));

    always_comb begin
        state_nxt     = state;
        stall         = 1'b0;
        pc_sel        = 1'b0;
        flush         = 1'b0;
        resolve_taken = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_branch && hazard) begin
                    stall = 1'b1;
                end else if (is_branch && cond_taken) begin
                    resolve_taken = 1'b1;
                    state_nxt     = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                // The instruction now in ID is wrong-path and is being flushed.
                pc_sel    = 1'b1;
                flush     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            br_target <= '0;
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (resolve_taken) begin
                br_target <= id_br_target;
                if (taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
            end
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
